// File: rtl/modn_counter.sv
// Modulo-N up/down counter with enable, synchronous clear, clamped parallel load,
// zero-latency terminal count for cascading, and a saturating wrap counter.
module modn_counter #(
  parameter int unsigned MODULUS = 3,
  parameter int unsigned WRAP_W  = 8,
  localparam int unsigned W      = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              up,
  input  logic              clr,
  input  logic              load,
  input  logic [W-1:0]      load_val,
  output logic [W-1:0]      count,
  output logic              tc,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  if (MODULUS < 2) begin : g_bad_modulus
    $error("modn_counter: MODULUS must be >= 2");
  end

  localparam logic [W-1:0]      CNT_MAX  = W'(MODULUS - 1);
  localparam logic [W:0]        MOD_EXT  = (W + 1)'(MODULUS);
  localparam logic [WRAP_W-1:0] WRAP_SAT = {WRAP_W{1'b1}};

  logic              at_top;
  logic              at_bot;
  logic              clamp;
  logic              wrap_evt;
  logic [W-1:0]      count_nxt;
  logic              err_nxt;
  logic [WRAP_W-1:0] wrap_nxt;

  // Next-state selection with priority clr > load > en > hold
  always_comb begin
    at_top    = (count == CNT_MAX);
    at_bot    = (count == '0);
    clamp     = ({1'b0, load_val} >= MOD_EXT);
    wrap_evt  = 1'b0;
    count_nxt = count;
    err_nxt   = 1'b0;
    wrap_nxt  = wrap_cnt;

    if (clr) begin
      count_nxt = '0;
      wrap_nxt  = '0;
    end else if (load) begin
      count_nxt = clamp ? CNT_MAX : load_val;
      err_nxt   = clamp;
    end else if (en) begin
      if (up) begin
        count_nxt = at_top ? '0 : count + W'(1);
        wrap_evt  = at_top;
      end else begin
        count_nxt = at_bot ? CNT_MAX : count - W'(1);
        wrap_evt  = at_bot;
      end
    end

    if (wrap_evt && (wrap_cnt != WRAP_SAT)) begin
      wrap_nxt = wrap_cnt + WRAP_W'(1);
    end
  end

  // Terminal count is combinational so a downstream stage's en sees it on the same edge
  always_comb begin
    tc = rstn & en & ~clr & ~load & ((up & at_top) | (~up & at_bot));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count    <= '0;
      load_err <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      count    <= count_nxt;
      load_err <= err_nxt;
      wrap_cnt <= wrap_nxt;
    end
  end

  a_count_in_range : assert property (@(posedge clk) disable iff (!rstn) count <= CNT_MAX);

endmodule

// File: tb/tb_modn_counter.sv
// Self-checking bench for modn_counter: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_modn_counter;

  logic clk;
  logic rstn;

  // MODULUS=3 instance
  logic       en3, up3, clr3, ld3;
  logic [1:0] lv3, cnt3;
  logic       tc3, err3;
  logic [7:0] wc3;
  // MODULUS=5 instance
  logic       en5, up5, clr5, ld5;
  logic [2:0] lv5, cnt5;
  logic       tc5, err5;
  logic [7:0] wc5;
  // MODULUS=2, WRAP_W=2 instance
  logic       en2, up2;
  logic [0:0] cnt2;
  logic       tc2, err2;
  logic [1:0] wc2;
  // Two-stage cascade of MODULUS=3
  logic       cen;
  logic [1:0] lo_cnt, hi_cnt;
  logic       lo_tc, hi_tc, lo_err, hi_err;
  logic [7:0] lo_wc, hi_wc;

  int n_checks = 0;
  int n_fail   = 0;

  modn_counter #(.MODULUS(3), .WRAP_W(8)) u_m3 (
    .clk(clk), .rstn(rstn), .en(en3), .up(up3), .clr(clr3), .load(ld3),
    .load_val(lv3), .count(cnt3), .tc(tc3), .load_err(err3), .wrap_cnt(wc3));

  modn_counter #(.MODULUS(5), .WRAP_W(8)) u_m5 (
    .clk(clk), .rstn(rstn), .en(en5), .up(up5), .clr(clr5), .load(ld5),
    .load_val(lv5), .count(cnt5), .tc(tc5), .load_err(err5), .wrap_cnt(wc5));

  modn_counter #(.MODULUS(2), .WRAP_W(2)) u_m2 (
    .clk(clk), .rstn(rstn), .en(en2), .up(up2), .clr(1'b0), .load(1'b0),
    .load_val(1'b0), .count(cnt2), .tc(tc2), .load_err(err2), .wrap_cnt(wc2));

  modn_counter #(.MODULUS(3), .WRAP_W(8)) u_lo (
    .clk(clk), .rstn(rstn), .en(cen), .up(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(2'd0), .count(lo_cnt), .tc(lo_tc), .load_err(lo_err), .wrap_cnt(lo_wc));

  modn_counter #(.MODULUS(3), .WRAP_W(8)) u_hi (
    .clk(clk), .rstn(rstn), .en(lo_tc), .up(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(2'd0), .count(hi_cnt), .tc(hi_tc), .load_err(hi_err), .wrap_cnt(hi_wc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one clock edge of a modulo-m counter, plain integer arithmetic
  task automatic model_step(input int m, input int wmax, input bit e, input bit u,
                            input bit c, input bit l, input int lv,
                            inout int cnt, inout int wrap, inout int err);
    int nxt;
    if (c) begin
      cnt = 0; wrap = 0; err = 0;
    end else if (l) begin
      err = (lv >= m) ? 1 : 0;
      cnt = (lv >= m) ? m - 1 : lv;
    end else begin
      err = 0;
      if (e) begin
        nxt = u ? cnt + 1 : cnt - 1;
        if (nxt < 0 || nxt >= m) begin
          if (wrap < wmax) wrap = wrap + 1;
        end
        cnt = (nxt + m) % m;
      end
    end
  endtask

  function automatic bit model_tc(input int m, input bit e, input bit u,
                                  input bit c, input bit l, input int cnt);
    int nxt;
    nxt = u ? cnt + 1 : cnt - 1;
    return e && !c && !l && (nxt < 0 || nxt >= m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en3 = 0; up3 = 0; clr3 = 0; ld3 = 0; lv3 = '0;
    en5 = 0; up5 = 0; clr5 = 0; ld5 = 0; lv5 = '0;
    en2 = 0; up2 = 0; cen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    en3 = 1; up3 = 0; en5 = 1; up5 = 0;
    #1;
    n_checks++; if (cnt3 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt3 got=%0d exp=0", cnt3); end
    n_checks++; if (tc3 !== 1'b0) begin n_fail++; $display("FAIL reset_tc3 got=%b exp=0", tc3); end
    n_checks++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL reset_err3 got=%b exp=0", err3); end
    n_checks++; if (wc3 !== 8'd0) begin n_fail++; $display("FAIL reset_wc3 got=%0d exp=0", wc3); end
    n_checks++; if (cnt5 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt5 got=%0d exp=0", cnt5); end
    n_checks++; if (tc5 !== 1'b0) begin n_fail++; $display("FAIL reset_tc5 got=%b exp=0", tc5); end
    n_checks++; if (wc2 !== 2'd0) begin n_fail++; $display("FAIL reset_wc2 got=%0d exp=0", wc2); end
    n_checks++; if (hi_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_hi got=%0d exp=0", hi_cnt); end
    @(negedge clk);
    clear_inputs();
    rstn = 1'b1;
  endtask

  task automatic test_up_mod3();
    int seq[7] = '{1, 2, 0, 1, 2, 0, 1};
    int prev;
    do_reset();
    en3 = 1; up3 = 1;
    prev = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      n_checks++;
      if (tc3 !== (prev == 2)) begin n_fail++; $display("FAIL up3_tc edge=%0d got=%b exp=%b", k, tc3, prev == 2); end
      tick();
      n_checks++;
      if (cnt3 !== 2'(seq[k])) begin n_fail++; $display("FAIL up3_cnt edge=%0d got=%0d exp=%0d", k, cnt3, seq[k]); end
      prev = seq[k];
    end
    n_checks++; if (wc3 !== 8'd2) begin n_fail++; $display("FAIL up3_wrap got=%0d exp=2", wc3); end
    en3 = 0;
  endtask

  task automatic test_down_mod5();
    int seq[6] = '{4, 3, 2, 1, 0, 4};
    int prev;
    en5 = 1; up5 = 0;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (tc5 !== (prev == 0)) begin n_fail++; $display("FAIL dn5_tc edge=%0d got=%b exp=%b", k, tc5, prev == 0); end
      tick();
      n_checks++;
      if (cnt5 !== 3'(seq[k])) begin n_fail++; $display("FAIL dn5_cnt edge=%0d got=%0d exp=%0d", k, cnt5, seq[k]); end
      prev = seq[k];
    end
    n_checks++; if (wc5 !== 8'd2) begin n_fail++; $display("FAIL dn5_wrap got=%0d exp=2", wc5); end
    en5 = 0;
  endtask

  task automatic test_load_clamp();
    int vals[4] = '{6, 2, 5, 7};
    int expc[4] = '{4, 2, 4, 4};
    int expe[4] = '{1, 0, 1, 1};
    for (int k = 0; k < 4; k++) begin
      ld5 = 1; lv5 = 3'(vals[k]); en5 = 1; up5 = 1;
      tick();
      n_checks++;
      if (cnt5 !== 3'(expc[k])) begin n_fail++; $display("FAIL load_cnt val=%0d got=%0d exp=%0d", vals[k], cnt5, expc[k]); end
      n_checks++;
      if (err5 !== 1'(expe[k])) begin n_fail++; $display("FAIL load_err val=%0d got=%b exp=%0d", vals[k], err5, expe[k]); end
      ld5 = 0; en5 = 0;
      tick();
      n_checks++;
      if (err5 !== 1'b0) begin n_fail++; $display("FAIL load_err_pulse val=%0d got=%b exp=0", vals[k], err5); end
      n_checks++;
      if (cnt5 !== 3'(expc[k])) begin n_fail++; $display("FAIL load_hold val=%0d got=%0d exp=%0d", vals[k], cnt5, expc[k]); end
    end
    n_checks++; if (wc5 !== 8'd2) begin n_fail++; $display("FAIL load_wrap_kept got=%0d exp=2", wc5); end
  endtask

  task automatic test_priority();
    ld3 = 1; lv3 = 2'd2; en3 = 0;
    tick();
    n_checks++; if (cnt3 !== 2'd2) begin n_fail++; $display("FAIL prio_preload got=%0d exp=2", cnt3); end
    clr3 = 1; ld3 = 1; lv3 = 2'd1; en3 = 1; up3 = 1;
    #1;
    n_checks++; if (tc3 !== 1'b0) begin n_fail++; $display("FAIL prio_clr_tc got=%b exp=0", tc3); end
    tick();
    n_checks++; if (cnt3 !== 2'd0) begin n_fail++; $display("FAIL prio_clr_cnt got=%0d exp=0", cnt3); end
    n_checks++; if (wc3 !== 8'd0) begin n_fail++; $display("FAIL prio_clr_wrap got=%0d exp=0", wc3); end
    clr3 = 0; ld3 = 1; lv3 = 2'd2; en3 = 0;
    tick();
    ld3 = 1; lv3 = 2'd1; en3 = 1; up3 = 1;
    #1;
    n_checks++; if (tc3 !== 1'b0) begin n_fail++; $display("FAIL prio_load_tc got=%b exp=0", tc3); end
    tick();
    n_checks++; if (cnt3 !== 2'd1) begin n_fail++; $display("FAIL prio_load_cnt got=%0d exp=1", cnt3); end
    n_checks++; if (wc3 !== 8'd0) begin n_fail++; $display("FAIL prio_load_wrap got=%0d exp=0", wc3); end
    ld3 = 0; en3 = 0;
  endtask

  task automatic test_wrap_sat();
    int expw;
    do_reset();
    en2 = 1; up2 = 1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      n_checks++;
      if (tc2 !== ((k - 1) % 2 == 1)) begin n_fail++; $display("FAIL sat_tc edge=%0d got=%b", k, tc2); end
      tick();
      expw = (k / 2 > 3) ? 3 : k / 2;
      n_checks++;
      if (wc2 !== 2'(expw)) begin n_fail++; $display("FAIL sat_wrap edge=%0d got=%0d exp=%0d", k, wc2, expw); end
      n_checks++;
      if (cnt2 !== 1'(k % 2)) begin n_fail++; $display("FAIL sat_cnt edge=%0d got=%0d exp=%0d", k, cnt2, k % 2); end
    end
    en2 = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    en3 = 1; up3 = 1;
    tick();
    tick();
    n_checks++; if (cnt3 !== 2'd2) begin n_fail++; $display("FAIL arst_pre got=%0d exp=2", cnt3); end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (cnt3 !== 2'd0) begin n_fail++; $display("FAIL arst_cnt got=%0d exp=0", cnt3); end
    n_checks++; if (tc3 !== 1'b0) begin n_fail++; $display("FAIL arst_tc got=%b exp=0", tc3); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    n_checks++; if (cnt3 !== 2'd1) begin n_fail++; $display("FAIL arst_resume got=%0d exp=1", cnt3); end
    en3 = 0;
  endtask

  task automatic test_cascade();
    do_reset();
    cen = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++;
      if (lo_cnt !== 2'(k % 3)) begin n_fail++; $display("FAIL casc_lo edge=%0d got=%0d exp=%0d", k, lo_cnt, k % 3); end
      n_checks++;
      if (hi_cnt !== 2'((k / 3) % 3)) begin n_fail++; $display("FAIL casc_hi edge=%0d got=%0d exp=%0d", k, hi_cnt, (k / 3) % 3); end
    end
    n_checks++; if (hi_wc !== 8'd1) begin n_fail++; $display("FAIL casc_hi_wrap got=%0d exp=1", hi_wc); end
    n_checks++; if (lo_wc !== 8'd3) begin n_fail++; $display("FAIL casc_lo_wrap got=%0d exp=3", lo_wc); end
    cen = 0;
  endtask

  task automatic test_random();
    int mc, mw, me;
    bit exp_tc;
    do_reset();
    mc = 0; mw = 0; me = 0;
    for (int k = 0; k < 400; k++) begin
      en5  = ($urandom_range(0, 3) != 0);
      up5  = 1'($urandom % 2);
      clr5 = ($urandom_range(0, 29) == 0);
      ld5  = ($urandom_range(0, 9) == 0);
      lv5  = 3'($urandom_range(0, 7));
      #1;
      exp_tc = model_tc(5, en5, up5, clr5, ld5, mc);
      n_checks++;
      if (tc5 !== exp_tc) begin n_fail++; $display("FAIL rnd_tc iter=%0d got=%b exp=%b", k, tc5, exp_tc); end
      model_step(5, 255, en5, up5, clr5, ld5, int'(lv5), mc, mw, me);
      tick();
      n_checks++;
      if (cnt5 !== 3'(mc)) begin n_fail++; $display("FAIL rnd_cnt iter=%0d got=%0d exp=%0d", k, cnt5, mc); end
      n_checks++;
      if (err5 !== 1'(me)) begin n_fail++; $display("FAIL rnd_err iter=%0d got=%b exp=%0d", k, err5, me); end
      n_checks++;
      if (wc5 !== 8'(mw)) begin n_fail++; $display("FAIL rnd_wrap iter=%0d got=%0d exp=%0d", k, wc5, mw); end
    end
    clear_inputs();
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_up_mod3();
    do_reset();
    test_down_mod5();
    test_load_clamp();
    test_priority();
    test_wrap_sat();
    test_async_reset();
    test_cascade();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
